add_mul_seq: RTL and testbench

ADD_MUL_SEQ -- requirements
Module: add_mul_seq

---
 rtl/add_mul_seq_pkg.sv | 11 +
 rtl/add_mul_seq_pp.sv | 33 +++
 rtl/add_mul_seq.sv | 131 +++++++++++++
 tb/tb_add_mul_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_mul_seq_pkg.sv
// Shared types and sizing helpers for the iterative (XS+XC)*Y multiplier.
package add_mul_seq_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // ceil((wx+1)/bpc): the multiplier is one bit wider than the addends
  function automatic int num_iter(input int wx, input int bpc);
    return (wx + bpc) / bpc;
  endfunction

endpackage

// File: rtl/add_mul_seq_pp.sv
// One partial-product row: sum of slice[j]*Y*2^j, with the top bit of the
// final slice weighted negatively in two's-complement mode.
module add_mul_seq_pp #(
  parameter int widthY       = 8,
  parameter int bitsPerCycle = 2
) (
  input  logic [bitsPerCycle-1:0]   slice,
  input  logic [widthY-1:0]         y,
  input  logic                      tc,
  input  logic                      top,
  output logic [widthY+bitsPerCycle:0] row
);

  localparam int widthR = widthY + bitsPerCycle + 1;

  logic signed [widthY-1:0] y_s;
  logic [widthR-1:0]        yext;

  assign y_s = y;

  always_comb begin
    if (tc) yext = widthR'(y_s);
    else    yext = widthR'(y);
    row = '0;
    for (int j = 0; j < bitsPerCycle; j++) begin
      if (slice[j]) begin
        if (tc && top && (j == bitsPerCycle - 1)) row = row - (yext << j);
        else                                      row = row + (yext << j);
      end
    end
  end

endmodule

// File: rtl/add_mul_seq.sv
// Sequential multiplier computing (XS+XC)*Y, retiring bitsPerCycle multiplier
// bits per cycle with a valid/ready handshake on both sides.
module add_mul_seq
  import add_mul_seq_pkg::*;
#(
  parameter int widthX       = 8,
  parameter int widthY       = 8,
  parameter int bitsPerCycle = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Flush,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic                     Tc,
  input  logic [widthX-1:0]        XS,
  input  logic [widthX-1:0]        XC,
  input  logic [widthY-1:0]        Y,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [widthX+widthY:0]   P
);

  localparam int widthM  = widthX + 1;
  localparam int numIter = num_iter(widthX, bitsPerCycle);
  localparam int widthP  = widthX + widthY + 1;
  localparam int widthE  = numIter * bitsPerCycle;
  localparam int widthR  = widthY + bitsPerCycle + 1;
  localparam int CW      = $clog2(numIter + 1);

  state_t state, state_n;

  logic [widthM-1:0] m_q;
  logic [widthY-1:0] y_q;
  logic              tc_q;
  logic [widthP-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              accept, last;

  logic signed [widthX-1:0] xs_s, xc_s;
  logic [widthM-1:0]        m_in;
  logic signed [widthM-1:0] m_s;
  logic [widthE-1:0]        mext;
  logic [bitsPerCycle-1:0]  slice;
  logic [widthR-1:0]        row;
  logic signed [widthR-1:0] row_s;
  logic [widthP-1:0]        row_p;
  int                       shamt;

  assign xs_s = XS;
  assign xc_s = XC;

  always_comb begin
    if (Tc) m_in = widthM'(xs_s) + widthM'(xc_s);
    else    m_in = widthM'(XS) + widthM'(XC);
  end

  // Extend M so the last slice is full; extension bits follow the mode
  assign m_s = m_q;
  always_comb begin
    if (tc_q) mext = widthE'(m_s);
    else      mext = widthE'(m_q);
  end

  assign shamt = int'(cnt) * bitsPerCycle;
  assign slice = bitsPerCycle'(mext >> shamt);
  assign last  = (cnt == CW'(numIter - 1));

  add_mul_seq_pp #(.widthY(widthY), .bitsPerCycle(bitsPerCycle)) u_pp (
    .slice (slice),
    .y     (y_q),
    .tc    (tc_q),
    .top   (last),
    .row   (row)
  );

  // Row may be one bit wider than P; modular arithmetic keeps the sum exact
  assign row_s = row;
  assign row_p = widthP'(row_s);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    InReady  = 1'b0;
    OutValid = 1'b0;
    case (state)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) state_n = BUSY;
      end
      BUSY: if (last) state_n = DONE;
      DONE: begin
        OutValid = 1'b1;
        InReady  = OutReady;
        if (OutReady) state_n = InValid ? BUSY : IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (Flush) state_n = IDLE;
  end

  assign accept = InValid & InReady & ~Flush;
  assign P      = (state == DONE) ? acc : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_q  <= '0;
      y_q  <= '0;
      tc_q <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
    end else if (Flush) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      m_q  <= m_in;
      y_q  <= Y;
      tc_q <= Tc;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == BUSY) begin
      acc <= acc + (row_p << shamt);
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_add_mul_seq.sv
// Directed and randomized checks of add_mul_seq against a behavioural product model.
module tb_add_mul_seq;

  logic        clk, rst, flush, in_valid, tc, out_ready;
  logic [7:0]  xs, xc, y;
  logic        in_ready, out_valid;
  logic [16:0] p;

  logic        sw_valid, sw_oready;
  logic        sw_ir [4];
  logic        sw_ov [4];
  logic [16:0] sw_p  [4];

  localparam int SW_BPC [4] = '{1, 2, 3, 9};
  localparam int SW_NIT [4] = '{9, 5, 3, 1};

  int checks = 0;
  int errors = 0;
  logic [16:0] q [$];

  add_mul_seq dut (
    .CLK(clk), .RST(rst), .Flush(flush), .InValid(in_valid), .InReady(in_ready),
    .Tc(tc), .XS(xs), .XC(xc), .Y(y), .OutValid(out_valid), .OutReady(out_ready), .P(p)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    add_mul_seq #(.widthX(8), .widthY(8), .bitsPerCycle(SW_BPC[g])) u_sw (
      .CLK(clk), .RST(rst), .Flush(flush), .InValid(sw_valid), .InReady(sw_ir[g]),
      .Tc(tc), .XS(xs), .XC(xc), .Y(y), .OutValid(sw_ov[g]), .OutReady(sw_oready), .P(sw_p[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] ref_p(input logic t, input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
    longint m, yy;
    if (t) begin
      m  = longint'($signed(a)) + longint'($signed(b));
      yy = longint'($signed(c));
    end else begin
      m  = longint'(a) + longint'(b);
      yy = longint'(c);
    end
    return 17'(m * yy);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic t, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    tc = t; xs = a; xc = b; y = c;
  endtask

  // present operands, confirm readiness, take the acceptance edge
  task automatic accept(input logic t, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drive(t, a, b, c);
    in_valid = 1'b1;
    chk("in_ready_accept", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  task automatic retire;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("retire_ov", 32'(out_valid), 32'd0);
    chk("retire_ir", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat, bad;
    int swlat [4];
    logic [16:0] e;
    rst = 1'b1; flush = 0; in_valid = 0; out_ready = 0; sw_valid = 0; sw_oready = 0;
    drive(0, 0, 0, 0);
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_p", 32'(p), 32'd0);
    #5 rst = 1'b0;
    tick;

    // Directed known products
    accept(1, 8'h7F, 8'h01, 8'h02);
    q.push_back(17'h00100);
    chk("busy_p_zero", 32'(p), 32'd0);
    wait_done(lat);
    chk("lat_033", 32'(lat), 32'd5);
    e = q.pop_front();
    chk("p_033", 32'(p), 32'(e));
    retire;

    accept(1, 8'h80, 8'h80, 8'hFF);
    q.push_back(17'h00100);
    wait_done(lat);
    chk("lat_034", 32'(lat), 32'd5);
    e = q.pop_front();
    chk("p_034", 32'(p), 32'(e));
    retire;

    accept(0, 8'hFF, 8'hFF, 8'hFF);
    q.push_back(17'h1FC02);
    wait_done(lat);
    chk("lat_035", 32'(lat), 32'd5);
    e = q.pop_front();
    chk("p_035", 32'(p), 32'(e));
    retire;

    // Back-to-back with InValid held, then backpressure
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(0, 8'h12, 8'h34, 8'h56);
    q.push_back(ref_p(0, 8'h12, 8'h34, 8'h56));
    tick;
    drive(1, 8'h90, 8'h05, 8'h7B);
    q.push_back(ref_p(1, 8'h90, 8'h05, 8'h7B));
    wait_done(lat);
    chk("lat_b2b_a", 32'(lat), 32'd5);
    e = q.pop_front();
    chk("p_b2b_a", 32'(p), 32'(e));
    chk("ir_b2b", 32'(in_ready), 32'd1);
    tick;
    out_ready = 1'b0;
    drive(0, 8'hAA, 8'h55, 8'h33);
    wait_done(lat);
    chk("lat_b2b_b", 32'(lat), 32'd5);
    e = q.pop_front();
    for (int i = 0; i < 3; i++) begin
      chk("hold_ov", 32'(out_valid), 32'd1);
      chk("hold_p", 32'(p), 32'(e));
      chk("hold_ir", 32'(in_ready), 32'd0);
      tick;
    end
    in_valid = 1'b0;
    chk("hold_p_end", 32'(p), 32'(e));
    retire;

    // Flush in the third BUSY cycle
    accept(0, 8'h21, 8'h43, 8'h65);
    tick;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_ir", 32'(in_ready), 32'd1);
    chk("flush_ov", 32'(out_valid), 32'd0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (out_valid) bad++;
    end
    chk("flush_no_out", 32'(bad), 32'd0);

    // Asynchronous reset mid-transaction
    accept(1, 8'h11, 8'h22, 8'h33);
    tick;
    #2 rst = 1'b1;
    #1;
    chk("arst_ir", 32'(in_ready), 32'd1);
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_p", 32'(p), 32'd0);
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (out_valid) bad++;
    end
    chk("arst_no_out", 32'(bad), 32'd0);

    // Sweep of slice widths, both modes, boundary operands first
    for (int n = 0; n < 24; n++) begin
      case (n)
        0: drive(0, 8'hFF, 8'hFF, 8'hFF);
        1: drive(1, 8'h80, 8'h80, 8'h80);
        2: drive(1, 8'h7F, 8'h7F, 8'h7F);
        3: drive(1, 8'h80, 8'h80, 8'h7F);
        default: drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
      endcase
      q.push_back(ref_p(tc, xs, xc, y));
      for (int k = 0; k < 4; k++) begin
        chk("sw_ir", 32'(sw_ir[k]), 32'd1);
        swlat[k] = -1;
      end
      sw_valid = 1'b1;
      tick;
      sw_valid = 1'b0;
      drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
      for (int c = 1; c <= 12; c++) begin
        tick;
        for (int k = 0; k < 4; k++)
          if (sw_ov[k] && swlat[k] < 0) swlat[k] = c;
      end
      e = q.pop_front();
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("sw_lat_bpc%0d", SW_BPC[k]), 32'(swlat[k]), 32'(SW_NIT[k]));
        chk($sformatf("sw_p_bpc%0d", SW_BPC[k]), 32'(sw_p[k]), 32'(e));
      end
      sw_oready = 1'b1;
      tick;
      sw_oready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
